pwm_gate_ctrl: RTL

Downstream stage of the constant-on-time generator. Combines the period-start `set` pulse with the on-time generator's `reset_pwm` into complementary high-side/low-side gate drives. Enforces programmable dead time and minimum off-time. Sits between the `ton` block and the gate-driver pins of the synchronous buck power stage.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_gate_ctrl_if.sv | 39 +++
 rtl/pwm_cnt_dn.sv | 26 ++
 rtl/pwm_gate_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and defaults for the PWM gate controller
package pwm_pkg;

    localparam int DT_WIDTH_DEF   = 8;
    localparam int TOFF_WIDTH_DEF = 16;
    localparam int STATE_W        = 3;
    localparam int MIN_DEAD_TIME  = 1;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DT_R  = 3'd1;
    localparam logic [STATE_W-1:0] ST_HS_ON = 3'd2;
    localparam logic [STATE_W-1:0] ST_DT_F  = 3'd3;
    localparam logic [STATE_W-1:0] ST_LS_ON = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = ST_IDLE,
        DT_R  = ST_DT_R,
        HS_ON = ST_HS_ON,
        DT_F  = ST_DT_F,
        LS_ON = ST_LS_ON
    } state_t;

endpackage

// File: rtl/pwm_gate_ctrl_if.sv
// rtl/pwm_gate_ctrl_if.sv - control inputs and gate outputs of pwm_gate_ctrl
// zcd exists only when PWM_GATE_ZCD_EN is defined.
interface pwm_gate_ctrl_if
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH   = DT_WIDTH_DEF,
    parameter int TOFF_WIDTH = TOFF_WIDTH_DEF
) ();

    logic                  en;
    logic                  set;
    logic                  reset_pwm;
    logic [DT_WIDTH-1:0]   dead_time;
    logic [TOFF_WIDTH-1:0] min_toff;
`ifdef PWM_GATE_ZCD_EN
    logic                  zcd;
`endif
    logic                  hs_gate;
    logic                  ls_gate;
    logic                  cycle_done;
    logic [STATE_W-1:0]    state;

    modport master (
`ifdef PWM_GATE_ZCD_EN
        output zcd,
`endif
        output en, set, reset_pwm, dead_time, min_toff,
        input  hs_gate, ls_gate, cycle_done, state
    );

    modport slave (
`ifdef PWM_GATE_ZCD_EN
        input  zcd,
`endif
        input  en, set, reset_pwm, dead_time, min_toff,
        output hs_gate, ls_gate, cycle_done, state
    );

endinterface

// File: rtl/pwm_cnt_dn.sv
// rtl/pwm_cnt_dn.sv - loadable down-counter that stops at zero
module pwm_cnt_dn #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pwm_gate_ctrl.sv
// rtl/pwm_gate_ctrl.sv - complementary HS/LS gate drive with dead time and minimum off-time
// Define PWM_GATE_ZCD_EN to add zero-current-detect exit from LS_ON (diode emulation).
module pwm_gate_ctrl
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH   = DT_WIDTH_DEF,
    parameter int TOFF_WIDTH = TOFF_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_gate_ctrl_if.slave bus
);

    state_t state_q, state_d;
    logic   set_d, set_edge, set_pend, rst_pend;
    logic   hs_q, ls_q, done_q, done_d;
    logic   dt_zero, off_zero, dt_load_en, off_load_en;
    logic [DT_WIDTH-1:0]   dt_load;
    logic [TOFF_WIDTH-1:0] toff_load;

    assign set_edge = bus.set & ~set_d;

    // Counters hold the cycles remaining after the current one, so a zero
    // flag at the edge means the programmed count has just been served.
    assign dt_load   = (bus.dead_time > DT_WIDTH'(MIN_DEAD_TIME)) ?
                       bus.dead_time - DT_WIDTH'(1) : DT_WIDTH'(MIN_DEAD_TIME - 1);
    assign toff_load = (bus.min_toff != '0) ? bus.min_toff - TOFF_WIDTH'(1) : '0;

    assign dt_load_en  = ((state_d == DT_R) && (state_q != DT_R)) ||
                         ((state_d == DT_F) && (state_q != DT_F));
    assign off_load_en = (state_d == LS_ON) && (state_q != LS_ON);

    pwm_cnt_dn #(.WIDTH(DT_WIDTH)) u_dt_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dt_load_en),
        .load_val (dt_load),
        .zero     (dt_zero)
    );

    pwm_cnt_dn #(.WIDTH(TOFF_WIDTH)) u_off_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (off_load_en),
        .load_val (toff_load),
        .zero     (off_zero)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (set_edge) state_d = DT_R;
                DT_R:  if (dt_zero) state_d = HS_ON;
                HS_ON: if (bus.reset_pwm || rst_pend) state_d = DT_F;
                DT_F:  if (dt_zero) state_d = LS_ON;
                LS_ON: begin
                    if (off_zero && (set_pend || set_edge)) begin
                        state_d = DT_R;
                        done_d  = 1'b1;
                    end
`ifdef PWM_GATE_ZCD_EN
                    else if (off_zero && bus.zcd) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
            done_q   <= 1'b0;
            set_d    <= 1'b0;
            set_pend <= 1'b0;
            rst_pend <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= (state_d == HS_ON);
            ls_q    <= (state_d == LS_ON);
            done_q  <= done_d;
            set_d   <= bus.set;
            if (!bus.en) begin
                set_pend <= 1'b0;
                rst_pend <= 1'b0;
            end else begin
                if ((state_q == DT_R) && bus.reset_pwm) begin
                    rst_pend <= 1'b1;
                end else if ((state_q == HS_ON) && (state_d != HS_ON)) begin
                    rst_pend <= 1'b0;
                end
                // Only one set edge is remembered during blanking.
                if (state_q == LS_ON) begin
                    if (state_d != LS_ON) begin
                        set_pend <= 1'b0;
                    end else if (!off_zero && set_edge) begin
                        set_pend <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.hs_gate    = hs_q;
    assign bus.ls_gate    = ls_q;
    assign bus.cycle_done = done_q;
    assign bus.state      = state_q;

endmodule
